// File: rtl/pipe_skid_reg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_skid_reg
// Description : Elastic pipeline register with a one-entry skid buffer.
//               It uses a valid/ready handshake on both sides. It sustains
//               one transfer per cycle, and in_ready comes straight from a
//               register. A synchronous flush discards every held entry.
// Options     : `define PIPE_STALL_CNT_EN adds a saturating 16-bit counter
//               of cycles where out_valid=1 and out_ready=0 (stall_cnt).
// Ports       : clk, reset (async, active-high), flush (sync)
//               in_valid / in_ready / in_data   - upstream side
//               out_valid / out_ready / out_data - downstream side
//               occupancy                        - held entries (0..2)
//               stall_cnt (optional)             - downstream stall cycles
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_skid_reg #(
    parameter int               WIDTH      = 32,
    parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
`ifdef PIPE_STALL_CNT_EN
    output logic [15:0]      stall_cnt,
`endif
    output logic [1:0]       occupancy
);

    // The state encoding doubles as the occupancy value.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;

    logic in_fire;
    logic out_fire;
    logic load_main_in;    // main <= in_data
    logic load_main_skid;  // main <= skid (drain the younger entry forward)
    logic load_skid;       // skid <= in_data

    // The handshake flags are pure decodes of the state register.
    assign out_valid = (state != EMPTY);
    assign in_ready  = (state != FULL);
    assign occupancy = state;
    assign out_data  = main_q;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        case (state)
            EMPTY: begin
                if (in_fire) begin
                    load_main_in = 1'b1;
                    state_nxt    = ONE;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    load_main_in = 1'b1;
                end else if (in_fire) begin
                    load_skid = 1'b1;
                    state_nxt = FULL;
                end else if (out_fire) begin
                    state_nxt = EMPTY;
                end
            end
            FULL: begin
                if (out_fire) begin
                    load_main_skid = 1'b1;
                    state_nxt      = ONE;
                end
            end
            default: state_nxt = EMPTY;
        endcase
        // Flush overrides everything. Any incoming beat is dropped, and the
        // data registers keep their old contents.
        if (flush) begin
            state_nxt      = EMPTY;
            load_main_in   = 1'b0;
            load_main_skid = 1'b0;
            load_skid      = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_q <= RESET_DATA;
            skid_q <= RESET_DATA;
        end else begin
            if (load_main_in) begin
                main_q <= in_data;
            end else if (load_main_skid) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= in_data;
            end
        end
    end

`ifdef PIPE_STALL_CNT_EN
    // Saturating counter. Only reset clears it; flush leaves it alone.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= 16'd0;
        end else if (out_valid && !out_ready && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_skid_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_skid_reg
// Description : Self-checking bench for pipe_skid_reg. It covers reset
//               (asynchronous and held), streaming, backpressure, flush, and
//               the optional stall counter (PIPE_STALL_CNT_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_skid_reg;

    localparam int          WIDTH = 32;
    localparam logic [31:0] RDATA = 32'h0000_A5A5;

    logic             clk;
    logic             reset;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       occupancy;
`ifdef PIPE_STALL_CNT_EN
    logic [15:0]      stall_cnt;
`endif

    int total = 0;
    int bad   = 0;

    pipe_skid_reg #(
        .WIDTH      (WIDTH),
        .RESET_DATA (RDATA)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
`ifdef PIPE_STALL_CNT_EN
        .stall_cnt (stall_cnt),
`endif
        .occupancy (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        fl;
        logic        iv;
        logic [31:0] d;
        logic        ordy;
        logic        ov;
        logic        ir;
        logic [1:0]  occ;
        logic [31:0] od;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic fl, logic iv, logic [31:0] d, logic ordy,
                                logic ov, logic ir, logic [1:0] occ, logic [31:0] od);
        vec_t v;
        v.fl = fl; v.iv = iv; v.d = d; v.ordy = ordy;
        v.ov = ov; v.ir = ir; v.occ = occ; v.od = od;
        return v;
    endfunction

    // Compares {out_valid, in_ready, occupancy, out_data} as one word.
    task automatic check(input string name, input logic ov, input logic ir,
                         input logic [1:0] occ, input logic [31:0] od);
        total++;
        if ({out_valid, in_ready, occupancy, out_data} !== {ov, ir, occ, od}) begin
            bad++;
            $display("FAIL %s: got ov=%0b ir=%0b occ=%0d od=%h, want ov=%0b ir=%0b occ=%0d od=%h",
                     name, out_valid, in_ready, occupancy, out_data, ov, ir, occ, od);
        end
    endtask

    // Drives inputs on the falling edge, then samples 1 time unit after the
    // next rising edge.
    task automatic step(input vec_t v, input string name);
        @(negedge clk);
        flush = v.fl; in_valid = v.iv; in_data = v.d; out_ready = v.ordy;
        @(posedge clk);
        #1;
        check(name, v.ov, v.ir, v.occ, v.od);
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'hDEAD_BEEF;
        // Reset held across edges with a valid input offered: nothing is captured.
        repeat (2) @(posedge clk);
        #1;
        check("reset_hold", 1'b0, 1'b1, 2'd0, RDATA);
        @(negedge clk);
        reset = 1'b0; in_valid = 1'b0;

        //            fl    iv    data          ordy  ov    ir    occ   out_data
        vecs.push_back(mk(1'b0, 1'b1, 32'h1,  1'b1, 1'b1, 1'b1, 2'd1, 32'h1));  // fill
        vecs.push_back(mk(1'b0, 1'b1, 32'h2,  1'b1, 1'b1, 1'b1, 2'd1, 32'h2));  // stream
        vecs.push_back(mk(1'b0, 1'b1, 32'h3,  1'b1, 1'b1, 1'b1, 2'd1, 32'h3));
        vecs.push_back(mk(1'b0, 1'b1, 32'h4,  1'b1, 1'b1, 1'b1, 2'd1, 32'h4));
        vecs.push_back(mk(1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 2'd0, 32'h4));  // drain
        vecs.push_back(mk(1'b0, 1'b1, 32'h11, 1'b0, 1'b1, 1'b1, 2'd1, 32'h11)); // A
        vecs.push_back(mk(1'b0, 1'b1, 32'h22, 1'b0, 1'b1, 1'b0, 2'd2, 32'h11)); // B -> skid
        vecs.push_back(mk(1'b0, 1'b1, 32'h33, 1'b0, 1'b1, 1'b0, 2'd2, 32'h11)); // C refused
        vecs.push_back(mk(1'b0, 1'b1, 32'h33, 1'b1, 1'b1, 1'b1, 2'd1, 32'h22)); // A out, C refused
        vecs.push_back(mk(1'b0, 1'b1, 32'h33, 1'b1, 1'b1, 1'b1, 2'd1, 32'h33)); // B out, C in
        vecs.push_back(mk(1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 2'd0, 32'h33)); // C out
        vecs.push_back(mk(1'b0, 1'b1, 32'h44, 1'b0, 1'b1, 1'b1, 2'd1, 32'h44));
        vecs.push_back(mk(1'b0, 1'b1, 32'h55, 1'b0, 1'b1, 1'b0, 2'd2, 32'h44)); // FULL
        vecs.push_back(mk(1'b1, 1'b1, 32'h66, 1'b0, 1'b0, 1'b1, 2'd0, 32'h44)); // flush FULL
        vecs.push_back(mk(1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 2'd0, 32'h44)); // idle
        vecs.push_back(mk(1'b0, 1'b1, 32'h77, 1'b1, 1'b1, 1'b1, 2'd1, 32'h77)); // EMPTY ignores ordy
        vecs.push_back(mk(1'b0, 1'b1, 32'h5A, 1'b1, 1'b1, 1'b1, 2'd1, 32'h5A)); // both fire in ONE
        vecs.push_back(mk(1'b1, 1'b1, 32'h88, 1'b1, 1'b0, 1'b1, 2'd0, 32'h5A)); // flush drops 88
        vecs.push_back(mk(1'b0, 1'b1, 32'h99, 1'b0, 1'b1, 1'b1, 2'd1, 32'h99));
        vecs.push_back(mk(1'b0, 1'b1, 32'hAA, 1'b0, 1'b1, 1'b0, 2'd2, 32'h99));
        vecs.push_back(mk(1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 2'd1, 32'hAA)); // skid forward
        vecs.push_back(mk(1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 2'd0, 32'hAA));
        vecs.push_back(mk(1'b1, 1'b1, 32'hBB, 1'b1, 1'b0, 1'b1, 2'd0, 32'hAA)); // flush in EMPTY

        foreach (vecs[i]) step(vecs[i], $sformatf("vec%0d", i));

        // Asynchronous reset taken from FULL, mid-cycle, with no clock edge.
        step(mk(1'b0, 1'b1, 32'hC1, 1'b0, 1'b1, 1'b1, 2'd1, 32'hC1), "pre_rst_one");
        step(mk(1'b0, 1'b1, 32'hC2, 1'b0, 1'b1, 1'b0, 2'd2, 32'hC1), "pre_rst_full");
        @(negedge clk);
        #2;
        reset = 1'b1; in_valid = 1'b1; in_data = 32'hDEAD_BEEF;
        #1;
        check("async_reset", 1'b0, 1'b1, 2'd0, RDATA);
        @(posedge clk);
        #1;
        check("reset_no_capture", 1'b0, 1'b1, 2'd0, RDATA);
        @(negedge clk);
        reset = 1'b0; in_valid = 1'b0;
        // The skid slot was reloaded with RESET_DATA. Fill it again and drain.
        step(mk(1'b0, 1'b1, 32'hC3, 1'b0, 1'b1, 1'b1, 2'd1, 32'hC3), "post_rst_one");
        step(mk(1'b0, 1'b1, 32'hC4, 1'b0, 1'b1, 1'b0, 2'd2, 32'hC3), "post_rst_full");
        step(mk(1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 2'd1, 32'hC4), "post_rst_drain");

`ifdef PIPE_STALL_CNT_EN
        @(negedge clk);
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        #1;
        total++;
        if (stall_cnt !== 16'd0) begin
            bad++; $display("FAIL stall_reset: got %h want 0000", stall_cnt);
        end
        @(negedge clk);
        reset = 1'b0;
        // This edge fills the register while out_valid is still 0, so it is not counted.
        step(mk(1'b0, 1'b1, 32'hE0, 1'b0, 1'b1, 1'b1, 2'd1, 32'hE0), "stall_fill");
        @(negedge clk);
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        total++;
        if (stall_cnt !== 16'd10) begin
            bad++; $display("FAIL stall_10: got %h want 000a", stall_cnt);
        end
        repeat (70000) @(posedge clk);
        #1;
        total++;
        if (stall_cnt !== 16'hFFFF) begin
            bad++; $display("FAIL stall_sat: got %h want ffff", stall_cnt);
        end
        step(mk(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 2'd0, 32'hE0), "stall_flush");
        total++;
        if (stall_cnt !== 16'hFFFF) begin
            bad++; $display("FAIL stall_after_flush: got %h want ffff", stall_cnt);
        end
        @(negedge clk);
        flush = 1'b0; reset = 1'b1;
        #1;
        total++;
        if (stall_cnt !== 16'd0) begin
            bad++; $display("FAIL stall_rereset: got %h want 0000", stall_cnt);
        end
        reset = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
